// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of the uart transmitter: accepts bytes over valid/ready and issues
// one registered wr_en/data_in load per byte whenever the transmitter reports idle.
module uart_tx_feeder #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [7:0]        data_in,
    output logic              wr_en,
    input  logic              Tx_busy,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              tx_err
);

    localparam int unsigned TW = $clog2(BUSY_TIMEOUT);
    localparam logic [TW-1:0] TimeoutLast = TW'(BUSY_TIMEOUT - 1);
    localparam logic [ADDR_W:0] CountFull = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StArm, StDrain} state_e;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    state_e            state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic              wr_en_q, wr_en_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              err_q, err_d;
    logic              push, pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CountFull);
    assign s_ready = !full;
    assign count   = count_q;
    assign data_in = data_q;
    assign wr_en   = wr_en_q;
    assign tx_err  = err_q;

    // A full FIFO refuses the push even when a pop happens in the same cycle.
    assign push = s_valid && !full;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        wr_en_d = 1'b0;
        timer_d = timer_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty && !Tx_busy) begin
                    data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
                    wr_en_d = 1'b1;
                    pop     = 1'b1;
                    timer_d = '0;
                    state_d = StArm;
                end
            end
            StArm: begin
                if (Tx_busy) begin
                    state_d = StDrain;
                end else if (timer_q == TimeoutLast) begin
                    // Transmitter never acknowledged the load; the byte is treated as consumed.
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDrain: begin
                if (!Tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            data_q   <= 8'h00;
            wr_en_q  <= 1'b0;
            timer_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            data_q   <= data_d;
            wr_en_q  <= wr_en_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= s_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomised scoreboard bench for uart_tx_feeder with a behavioural uart transmitter model
// that loops loaded bytes into a receive log.
module tb_uart_tx_feeder;

    localparam int M_LOOP = 0;
    localparam int M_HOLD = 1;
    localparam int M_STUB = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] data_in;
    logic       wr_en;
    logic       Tx_busy = 1'b0;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       tx_err;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    int         rx_log[$];
    int         wr_edges[$];
    int         wr_cnt = 0;
    int         cyc = 0;
    int         err_edge = -1;
    bit         mon_en = 1'b0;
    int         umode = M_LOOP;
    int         frame_len = 6;
    bit         frame_rand = 1'b0;
    int         busy_cnt = 0;

    uart_tx_feeder #(
        .DEPTH(16),
        .ADDR_W(4),
        .BUSY_TIMEOUT(4)
    ) dut (
        .clk_50m(clk),
        .rst(rst),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .data_in(data_in),
        .wr_en(wr_en),
        .Tx_busy(Tx_busy),
        .count(count),
        .empty(empty),
        .full(full),
        .tx_err(tx_err)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Behavioural uart: a load starts a frame that keeps Tx_busy high for its length,
    // after which the byte appears in the receive log.
    logic [7:0] shreg = 8'h00;
    always begin
        @(posedge clk);
        #1;
        if (umode == M_LOOP) begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) rx_log.push_back(int'(shreg));
            end else if (wr_en === 1'b1) begin
                shreg = data_in;
                busy_cnt = frame_rand ? int'($urandom_range(1, 7)) : frame_len;
            end
        end
        #1;
        Tx_busy = (umode == M_HOLD) || (umode == M_LOOP && busy_cnt > 0);
    end

    // Monitor / scoreboard: accepted bytes enter the expected queue, loads pop it.
    logic [7:0] held_data = 8'h00;
    bit         prev_wr = 1'b0;
    bit         prev_err = 1'b0;
    always begin
        bit         acc;
        bit         rst_s;
        logic [7:0] dat;
        @(negedge clk);
        acc   = (s_valid === 1'b1) && (s_ready === 1'b1);
        rst_s = (rst === 1'b1);
        dat   = s_data;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) begin
            exp_q.delete();
            held_data = 8'h00;
            prev_wr = 1'b0;
            if (mon_en) begin
                check("rst_wr_en", 32'(wr_en), 32'd0);
                check("rst_count", 32'(count), 32'd0);
            end
        end else if (mon_en) begin
            if (acc) exp_q.push_back(dat);
            if (wr_en === 1'b1) begin
                check("wr_en_gap", 32'(prev_wr), 32'd0);
                check("busy_at_load", 32'(Tx_busy), 32'd0);
                if (exp_q.size() == 0) begin
                    bound_fail("unexpected_load");
                end else begin
                    check("load_data", 32'(data_in), 32'(exp_q.pop_front()));
                end
                held_data = data_in;
                wr_cnt++;
                wr_edges.push_back(cyc);
            end else begin
                check("data_in_stable", 32'(data_in), 32'(held_data));
            end
            check("count", 32'(count), 32'(exp_q.size()));
            check("empty", 32'(empty), 32'(exp_q.size() == 0));
            check("full", 32'(full), 32'(exp_q.size() == 16));
            check("s_ready", 32'(s_ready), 32'(exp_q.size() != 16));
            prev_wr = (wr_en === 1'b1);
        end
        if (tx_err === 1'b1 && !prev_err) err_edge = cyc;
        prev_err = (tx_err === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit keep, output int edge_o);
        int n = 0;
        bit acc = 1'b0;
        edge_o = -1;
        s_data = b;
        s_valid = 1'b1;
        while (!acc && n < 500) begin
            @(negedge clk);
            if (s_ready === 1'b1 && rst === 1'b0) begin
                acc = 1'b1;
                edge_o = cyc + 1;
            end
            @(posedge clk);
            #2;
            n++;
        end
        if (!keep) s_valid = 1'b0;
        if (!acc) bound_fail("send_accept");
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_wr(input int target);
        int n = 0;
        while (wr_cnt < target && n < 500) begin
            tick(1);
            n++;
        end
        if (wr_cnt < target) bound_fail("wait_wr_en");
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy_cnt != 0 || Tx_busy === 1'b1) && n < 3000) begin
            tick(1);
            n++;
        end
        if (n >= 3000) bound_fail("wait_idle");
        tick(8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int e10;
        int base;
        int rxb;
        int sent[$];

        // 1: reset values, then a single byte through the loopback
        tick(3);
        do_reset();
        mon_en = 1'b1;
        check("reset_data_in", 32'(data_in), 32'h00);
        check("reset_wr_en", 32'(wr_en), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_tx_err", 32'(tx_err), 32'd0);
        base = wr_cnt;
        rxb = rx_log.size();
        send(8'h00, 1'b0, e);
        wait_wr(base + 1);
        check("t1_latency", 32'((wr_edges.size() > base) ? wr_edges[base] : -1), 32'(e + 1));
        wait_idle();
        check("t1_rx_count", 32'(rx_log.size() - rxb), 32'd1);
        check("t1_rx_data", 32'((rx_log.size() > rxb) ? rx_log[rxb] : -1), 32'h00);

        // 2/3: fill while busy, stall on full, then drain in order
        umode = M_HOLD;
        tick(2);
        rxb = rx_log.size();
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0, e);
        tick(1);
        check("t2_count_full", 32'(count), 32'd16);
        check("t2_full", 32'(full), 32'd1);
        check("t2_s_ready", 32'(s_ready), 32'd0);
        base = wr_cnt;
        fork
            send(8'h10, 1'b0, e10);
            begin
                tick(3);
                check("t2_stall_count", 32'(count), 32'd16);
                umode = M_LOOP;
                wait_wr(base + 1);
            end
        join
        check("t3_accept_after_pop", 32'(e10),
              32'((wr_edges.size() > base) ? wr_edges[base] + 1 : -1));
        check("t3_count_refill", 32'(count), 32'd16);
        wait_idle();
        check("t2_rx_count", 32'(rx_log.size() - rxb), 32'd17);
        for (int i = 0; i < 17; i++)
            check("t2_rx_order", 32'((rx_log.size() > rxb + i) ? rx_log[rxb + i] : -1), 32'(i));
        check("t2_wr_count", 32'(wr_cnt - base), 32'd17);

        // 4: transmitter never raises busy -> sticky timeout error
        check("t4_tx_err_clean", 32'(tx_err), 32'd0);
        umode = M_STUB;
        tick(2);
        base = wr_cnt;
        send(8'hA5, 1'b0, e);
        send(8'h5A, 1'b0, e);
        tick(20);
        check("t4_wr_count", 32'(wr_cnt - base), 32'd2);
        check("t4_err_delay", 32'((wr_edges.size() > base) ? err_edge - wr_edges[base] : -1),
              32'd4);
        check("t4_second_load",
              32'((wr_edges.size() > base + 1) ? wr_edges[base + 1] - wr_edges[base] : -1), 32'd5);
        check("t4_tx_err_sticky", 32'(tx_err), 32'd1);

        // 5: reset with bytes queued and a frame in flight
        umode = M_LOOP;
        frame_len = 30;
        tick(2);
        for (int i = 0; i < 6; i++) send(8'h80 + 8'(i), 1'b0, e);
        check("t5_queued", 32'(count), 32'd5);
        do_reset();
        check("t5_count", 32'(count), 32'd0);
        check("t5_wr_en", 32'(wr_en), 32'd0);
        check("t5_data_in", 32'(data_in), 32'h00);
        check("t5_tx_err", 32'(tx_err), 32'd0);
        base = wr_cnt;
        send(8'h33, 1'b0, e);
        wait_wr(base + 1);
        check("t5_data_33", 32'(data_in), 32'h33);
        wait_idle();
        check("t5_single_pulse", 32'(wr_cnt - base), 32'd1);

        // 6: 40-byte stream with s_valid held high (pointers wrap twice)
        frame_len = 4;
        rxb = rx_log.size();
        for (int i = 0; i < 40; i++) send(8'(i), (i < 39), e);
        wait_idle();
        check("t6_rx_count", 32'(rx_log.size() - rxb), 32'd40);
        for (int i = 0; i < 40; i++)
            check("t6_rx_order", 32'((rx_log.size() > rxb + i) ? rx_log[rxb + i] : -1), 32'(i));
        check("t6_tx_err", 32'(tx_err), 32'd0);

        // 7: random bytes, random gaps, random frame lengths
        frame_rand = 1'b1;
        rxb = rx_log.size();
        for (int i = 0; i < 60; i++) begin
            sent.push_back(int'($urandom_range(0, 255)));
            send(8'(sent[i]), 1'b0, e);
            tick(int'($urandom_range(0, 3)));
        end
        wait_idle();
        check("t7_rx_count", 32'(rx_log.size() - rxb), 32'd60);
        for (int i = 0; i < 60; i++)
            check("t7_rx_data", 32'((rx_log.size() > rxb + i) ? rx_log[rxb + i] : -1),
                  32'(sent[i]));
        check("t7_tx_err", 32'(tx_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Byte-queue front end that sits directly upstream of the uart transceiver and drives its data_in/wr_en transmit interface. Producers push bytes through a valid/ready handshake into an internal FIFO. A small FSM issues exactly one wr_en pulse per byte, and only when the transmitter is idle (Tx_busy low). This replaces hand-sequenced wr_en pulses with back-pressured streaming.

Parameters:
DEPTH, 16, FIFO entries; must be a power of two, at least 2
ADDR_W, 4, log2(DEPTH)
BUSY_TIMEOUT, 4, cycles to wait after wr_en for Tx_busy to rise before declaring a missed load; at least 2

Ports:
clk_50m  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
s_data  in  8  byte from producer
s_valid  in  1  producer has a byte
s_ready  out  1  FIFO can accept; a push happens when s_valid & s_ready at a rising edge
data_in  out  8  byte to uart transmitter (connects to uart data_in)
wr_en  out  1  single-cycle load strobe to uart (connects to uart wr_en)
Tx_busy  in  1  uart transmitter busy
count  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
tx_err  out  1  sticky flag: Tx_busy never rose after a load

Behaviour:
- Reset (rst high at an edge):
  - data_in=0x00, wr_en=0, count=0, read/write pointers=0, state=IDLE, timeout counter=0, tx_err=0.
  - FIFO contents are discarded.
  - Reset overrides every other event in the same cycle.
- FIFO:
  - Pointers are ADDR_W+1 bits and wrap naturally; memory is indexed by the low ADDR_W bits.
  - s_ready, empty and full are combinational from the registered count. s_ready = !full.
  - A push while full is not accepted, even if a pop occurs in the same cycle. The producer holds the byte and it is accepted on the next cycle.
  - Push and pop in the same cycle (not full): count is unchanged, both pointers advance.
- FSM states:
  - IDLE: if !empty && !Tx_busy, register data_in <= mem[rd_ptr], wr_en <= 1, pop (rd_ptr+1, count-1), clear the timeout counter, go to ARM. Otherwise wr_en <= 0.
  - ARM: wr_en <= 0.
    - If Tx_busy == 1, go to DRAIN.
    - Else increment the timeout counter. When it reaches BUSY_TIMEOUT-1, set tx_err <= 1 and go to IDLE; the byte is considered consumed.
  - DRAIN: wait until Tx_busy == 0, then go to IDLE.
- wr_en timing:
  - wr_en is high for exactly one clk_50m cycle per popped byte. It is never asserted in consecutive cycles.
  - The minimum spacing between pulses is the full Tx_busy high period plus 1 cycle.
- data_in is registered and stays stable from the load edge until the next load, so the uart may sample it late.
- Latency: a push accepted at edge E0 into an empty FIFO, with Tx_busy low, gives wr_en=1 and data_in=byte after edge E1 (one cycle later), deasserting at E2.
- Ordering: strict FIFO order; no byte is dropped or duplicated unless reset intervenes.
- Tx_busy high in IDLE (for example a transmission still running after a feeder-only reset): no load occurs until it falls.
- tx_err clears only on rst.

Test Plan:
1. Reset, then push 0x00 with Tx/Rx looped back through uart -> wr_en high for exactly one cycle, one cycle after the push; data_in=0x00; uart ready rises with data_out=0x00.
2. Hold Tx_busy high and push 0x00..0x0F -> count=16, full=1, s_ready=0; push 0x10 stalls. Release Tx_busy -> bytes leave in order 0x00..0x0F, one wr_en each; every wr_en follows a Tx_busy fall; 0x10 is accepted on the first pop cycle after it.
3. Full FIFO, s_valid held high during a pop cycle -> no accept that cycle; accepted the next cycle with count back to 16.
4. Tx_busy stubbed to 0, BUSY_TIMEOUT=4, push 0xA5, 0x5A -> tx_err=1 four cycles after the first wr_en; 0x5A is loaded next; tx_err stays 1.
5. Five bytes queued and the uart mid-frame, assert rst for one cycle -> count=0, wr_en=0, data_in=0x00. After a push of 0x33, wr_en waits for Tx_busy low, then a single pulse with 0x33.
6. Loopback stream of 40 bytes, 0x00..0x27, with s_valid always high -> pointers wrap twice; received sequence matches exactly; tx_err=0.
